// File: rtl/pong_telemetry_tx_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared constants and types for the pong host link (telemetry transmitter
// and the UART receive path in the input bridge).
//   SYNC_BYTE     : packet header byte
//   PKT_LEN       : bytes per status packet
//   GAME_OVER_BIT : flag position of game_over in the flags byte
//   STARTUP_BIT   : flag position of game_startup in the flags byte
//   FRAME_BITS    : serial bits per byte frame (start + 8 data + stop)
//   clks_per_bit(): clock cycles per serial bit (integer truncation)
// ---------------------------------------------------------------------------
package pong_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam int         PKT_LEN       = 4;
   localparam int         GAME_OVER_BIT = 0;
   localparam int         STARTUP_BIT   = 1;
   localparam int         SCORE_W       = 4;
   localparam int         FRAME_BITS    = 10;

   // Packed in the same order the status vector is specified:
   // {score_p1, score_p2, game_over, game_startup}
   typedef struct packed {
      logic [SCORE_W-1:0] score_p1;
      logic [SCORE_W-1:0] score_p2;
      logic               game_over;
      logic               game_startup;
   } status_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } tx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/pong_telemetry_tx_if.sv
// ---------------------------------------------------------------------------
// pong_telemetry_tx_if
// Game-state inputs and serial/status outputs of the telemetry transmitter.
//   score_p1, score_p2 : player scores (0-15)
//   game_over          : game-over flag
//   game_startup       : start-menu/startup flag
//   force_send         : single-cycle request for a packet
//   uart_tx            : serial line, idle high
//   busy               : packet in progress
//   pkt_sent           : one-cycle pulse when a packet finishes
// master drives the game state (game logic / bench), slave is the transmitter.
// ---------------------------------------------------------------------------
interface pong_telemetry_tx_if;
   import pong_pkg::*;

   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;
   logic               game_over;
   logic               game_startup;
   logic               force_send;
   logic               uart_tx;
   logic               busy;
   logic               pkt_sent;

   modport master (
      output score_p1, score_p2, game_over, game_startup, force_send,
      input  uart_tx, busy, pkt_sent
   );

   modport slave (
      input  score_p1, score_p2, game_over, game_startup, force_send,
      output uart_tx, busy, pkt_sent
   );

endinterface

// File: rtl/pong_telemetry_tx_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serialiser. Accepts a byte on valid&&ready and shifts it out LSB
// first framed by a start bit (0) and a stop bit (1), each bit held for
// CLKS_PER_BIT cycles.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   data  : byte to send, sampled on valid&&ready
//   valid : data is available
//   ready : high when idle and in the last cycle of a stop bit, so a byte
//           offered then starts immediately with no gap
//   tx    : serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx_byte
   import pong_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]     STOP_IDX = 4'(FRAME_BITS - 1);

   logic             active;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]       shreg;
   logic             tx_r;
   logic             bit_end;
   logic             frame_end;
   logic             load;

   assign bit_end   = active && (baud_cnt == CNT_LAST);
   assign frame_end = bit_end && (bit_idx == STOP_IDX);
   assign ready     = !active || frame_end;
   assign load      = valid && ready;
   assign tx        = tx_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx_r     <= 1'b1;
      end else if (load) begin
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx_r     <= 1'b0;
      end else if (frame_end) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx_r     <= 1'b1;
      end else if (bit_end) begin
         baud_cnt <= '0;
         bit_idx  <= bit_idx + 4'd1;
         // After data bit 7 the next bit is the stop bit
         tx_r     <= (bit_idx < 4'd8) ? shreg[0] : 1'b1;
      end else if (active) begin
         baud_cnt <= baud_cnt + CNT_W'(1);
      end
   end

   // Data shifter: no reset needed, contents only matter once loaded
   always_ff @(posedge clk) begin
      if (load) begin
         shreg <= data;
      end else if (bit_end && (bit_idx < 4'd8)) begin
         shreg <= {1'b0, shreg[7:1]};
      end
   end

endmodule

// File: rtl/pong_telemetry_tx.sv
// ---------------------------------------------------------------------------
// pong_telemetry_tx
// Host-bound UART telemetry. Sends a 4-byte status packet
//   {SYNC_BYTE, {score_p1,score_p2}, flags, xor-checksum}
// whenever the registered game state differs from the last packet sent, or
// when force_send was pulsed. Triggers arriving mid-packet collapse into a
// single follow-up packet carrying the values current when it starts.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : slave side of pong_telemetry_tx_if (game state in, uart_tx/busy/
//         pkt_sent out)
// ---------------------------------------------------------------------------
module pong_telemetry_tx
   import pong_pkg::*;
#(
   parameter int         CLK_FREQ     = 50_000_000,
   parameter int         BAUD         = 115200,
   parameter int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
   parameter logic [7:0] SYNC_BYTE    = pong_pkg::SYNC_BYTE
) (
   input  logic                clk,
   input  logic                rst,
   pong_telemetry_tx_if.slave  bus
);

   localparam logic [2:0] LAST_IDX = 3'(PKT_LEN);

   status_t   status_in;
   status_t   status_p1;
   status_t   last_sent;
   status_t   pkt_status;
   logic      force_p1;
   logic      pending;
   logic      trigger;
   logic      go;
   logic [2:0] byte_idx;     // next byte to hand over; LAST_IDX = all handed
   tx_state_t state;
   tx_state_t state_nxt;
   logic      tx_valid;
   logic      tx_ready;
   logic [7:0] tx_data;
   logic      tx_line;

   function automatic logic [7:0] pkt_byte(input status_t s, input logic [1:0] idx);
      logic [7:0] b1;
      logic [7:0] b2;
      b1                = {s.score_p1, s.score_p2};
      b2                = '0;
      b2[GAME_OVER_BIT] = s.game_over;
      b2[STARTUP_BIT]   = s.game_startup;
      case (idx)
         2'd0:    pkt_byte = SYNC_BYTE;
         2'd1:    pkt_byte = b1;
         2'd2:    pkt_byte = b2;
         default: pkt_byte = SYNC_BYTE ^ b1 ^ b2;
      endcase
   endfunction

   assign status_in = {bus.score_p1, bus.score_p2, bus.game_over, bus.game_startup};
   assign trigger   = (status_p1 != last_sent) || force_p1;
   assign go        = (state == ST_IDLE) && (trigger || pending) && tx_ready;

   // Stage p1: registered status and force request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_p1 <= '0;
         force_p1  <= 1'b0;
      end else begin
         status_p1 <= status_in;
         force_p1  <= bus.force_send;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         last_sent <= '0;
         pending   <= 1'b0;
         byte_idx  <= '0;
      end else begin
         state <= state_nxt;
         if (go) begin
            last_sent <= status_p1;
            pending   <= 1'b0;
            byte_idx  <= 3'd1;   // B0 is handed over on the leaving edge
         end else begin
            if ((state != ST_IDLE) && trigger) begin
               pending <= 1'b1;
            end
            if ((state == ST_SEND) && tx_valid && tx_ready) begin
               byte_idx <= byte_idx + 3'd1;
            end else if (state == ST_DONE) begin
               byte_idx <= '0;
            end
         end
      end
   end

   // Packet buffer: frozen for the whole packet, so later input changes
   // cannot leak into a packet in flight
   always_ff @(posedge clk) begin
      if (go) begin
         pkt_status <= status_p1;
      end
   end

   always_comb begin
      state_nxt = state;
      tx_valid  = 1'b0;
      tx_data   = pkt_byte(pkt_status, byte_idx[1:0]);
      case (state)
         ST_IDLE: begin
            // B0 is the constant header, so it can go out on the very edge
            // that latches the snapshot
            tx_data = SYNC_BYTE;
            if ((trigger || pending) && tx_ready) begin
               tx_valid  = 1'b1;
               state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (byte_idx != LAST_IDX) begin
               tx_valid = 1'b1;
            end else if (tx_ready) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk   (clk),
      .rst   (rst),
      .data  (tx_data),
      .valid (tx_valid),
      .ready (tx_ready),
      .tx    (tx_line)
   );

   assign bus.uart_tx  = tx_line;
   assign bus.busy     = (state == ST_SEND);
   assign bus.pkt_sent = (state == ST_DONE);

endmodule

// File: tb/tb_pong_telemetry_tx.sv
// ---------------------------------------------------------------------------
// tb_pong_telemetry_tx
// Directed bench for pong_telemetry_tx, run with a 10-cycle bit time
// (CLK_FREQ=1000, BAUD=100). A serial decoder samples uart_tx mid-bit and
// every expected byte and timing value is hand-computed below.
// ---------------------------------------------------------------------------
module tb_pong_telemetry_tx;

   localparam int CPB        = 10;        // 1000 / 100
   localparam int PKT_CYC    = 40 * CPB;
   localparam int RX_TIMEOUT = 3000;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   pkt_cnt;
   int   last_pkt_cyc;
   logic busy_at_pkt;

   pong_telemetry_tx_if bus ();

   pong_telemetry_tx #(
      .CLK_FREQ (1000),
      .BAUD     (100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      pkt_cnt      = 0;
      last_pkt_cyc = -1;
      busy_at_pkt  = 1'b0;
   end

   always @(negedge clk) begin
      if (bus.pkt_sent === 1'b1) begin
         pkt_cnt      = pkt_cnt + 1;
         last_pkt_cyc = cyc;
         busy_at_pkt  = bus.busy;
      end
   end

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic rx_byte(input string tag, output logic [7:0] d, output int t_start);
      int waited;
      waited  = 0;
      d       = '0;
      t_start = -1;
      @(negedge clk);
      while (bus.uart_tx !== 1'b0 && waited < RX_TIMEOUT) begin
         @(negedge clk);
         waited++;
      end
      if (bus.uart_tx !== 1'b0) begin
         check_val({tag, " start timeout"}, 32'd0, 32'd1);
         return;
      end
      t_start = cyc;
      check_val({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
      repeat (CPB / 2) @(negedge clk);
      check_val({tag, " start bit"}, {31'd0, bus.uart_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         d[i] = bus.uart_tx;
      end
      repeat (CPB) @(negedge clk);
      check_val({tag, " stop bit"}, {31'd0, bus.uart_tx}, 32'd1);
   endtask

   // exp = {B3, B2, B1, B0}
   task automatic rx_pkt(input string tag, input logic [31:0] exp, output int t0);
      logic [7:0] d;
      int ts;
      int tprev;
      t0    = -1;
      tprev = -1;
      for (int i = 0; i < 4; i++) begin
         rx_byte($sformatf("%s b%0d", tag, i), d, ts);
         if (i == 0) t0 = ts;
         check_val($sformatf("%s b%0d value", tag, i), {24'd0, d}, {24'd0, exp[8*i +: 8]});
         if (i > 0) check_val($sformatf("%s gap%0d", tag, i), ts - tprev, 10 * CPB);
         tprev = ts;
      end
   endtask

   task automatic wait_pkt(input string tag, input int target);
      int n;
      n = 0;
      while (pkt_cnt < target && n < RX_TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, " pkt_sent count"}, pkt_cnt, target);
   endtask

   task automatic quiet(input string tag, input int n);
      int lows;
      int busies;
      lows   = 0;
      busies = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.uart_tx !== 1'b1) lows++;
         if (bus.busy !== 1'b0) busies++;
      end
      check_val({tag, " tx low cycles"}, lows, 0);
      check_val({tag, " busy cycles"}, busies, 0);
   endtask

   task automatic drive_state(input logic [3:0] p1, input logic [3:0] p2,
                              input logic go_f, input logic st_f);
      bus.score_p1     = p1;
      bus.score_p2     = p2;
      bus.game_over    = go_f;
      bus.game_startup = st_f;
   endtask

   initial begin
      int k;
      int t0;
      int c0;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive_state(4'd0, 4'd0, 1'b0, 1'b0);
      bus.force_send = 1'b0;
      #1 rst = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("reset uart_tx", {31'd0, bus.uart_tx}, 32'd1);
      check_val("reset busy", {31'd0, bus.busy}, 32'd0);
      check_val("reset pkt_sent", {31'd0, bus.pkt_sent}, 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Idle with zero inputs: nothing sent
      quiet("idle", 5000);
      check_val("idle pkt count", pkt_cnt, 0);

      // 3/5 -> A5 35 00 90, start bit on 2nd edge after change
      @(posedge clk); #1;
      drive_state(4'd3, 4'd5, 1'b0, 1'b0);
      k = cyc;
      rx_pkt("p35", 32'h90_00_35_A5, t0);
      check_val("p35 latency", t0, k + 2);
      wait_pkt("p35", 1);
      check_val("p35 pkt_sent time", last_pkt_cyc, t0 + PKT_CYC);
      check_val("p35 busy at pkt_sent", {31'd0, busy_at_pkt}, 32'd0);
      quiet("p35 after", 100);

      // 9/7 game_over -> A5 97 01 33
      @(posedge clk); #1;
      drive_state(4'd9, 4'd7, 1'b1, 1'b0);
      k = cyc;
      rx_pkt("p97", 32'h33_01_97_A5, t0);
      check_val("p97 latency", t0, k + 2);
      wait_pkt("p97", 2);
      check_val("p97 pkt_sent time", last_pkt_cyc, t0 + PKT_CYC);
      quiet("p97 after", 100);

      // 3/1 packet, score_p2 changed 3x mid-packet -> one follow-up 3/6
      c0 = pkt_cnt;
      @(posedge clk); #1;
      drive_state(4'd3, 4'd1, 1'b0, 1'b0);
      fork
         rx_pkt("p31", 32'h94_00_31_A5, t0);
         begin
            repeat (50) @(posedge clk);
            #1 bus.score_p2 = 4'd2;
            repeat (50) @(posedge clk);
            #1 bus.score_p2 = 4'd4;
            repeat (50) @(posedge clk);
            #1 bus.score_p2 = 4'd6;
         end
      join
      rx_pkt("p36 pend", 32'h93_00_36_A5, t0);
      check_val("pend follow-up start", t0, last_pkt_cyc + 2);
      wait_pkt("pend", c0 + 2);
      quiet("pend after", 3 * PKT_CYC);
      check_val("pend packet count", pkt_cnt, c0 + 2);

      // force_send with unchanged state 3/6
      c0 = pkt_cnt;
      @(posedge clk); #1 bus.force_send = 1'b1;
      k = cyc;
      @(posedge clk); #1 bus.force_send = 1'b0;
      rx_pkt("force", 32'h93_00_36_A5, t0);
      check_val("force latency", t0, k + 2);
      wait_pkt("force", c0 + 1);
      quiet("force after", 3 * PKT_CYC);
      check_val("force packet count", pkt_cnt, c0 + 1);

      // force_send coincident with change to 4/6 -> exactly one A5 46 00 E3
      c0 = pkt_cnt;
      @(posedge clk); #1;
      bus.force_send = 1'b1;
      bus.score_p1   = 4'd4;
      k = cyc;
      @(posedge clk); #1 bus.force_send = 1'b0;
      rx_pkt("coinc", 32'hE3_00_46_A5, t0);
      check_val("coinc latency", t0, k + 2);
      wait_pkt("coinc", c0 + 1);
      quiet("coinc after", 3 * PKT_CYC);
      check_val("coinc packet count", pkt_cnt, c0 + 1);

      // Reset in data bit 2 of B1 (0x12: bit2 = 0, line low)
      c0 = pkt_cnt;
      @(posedge clk); #1;
      drive_state(4'd1, 4'd2, 1'b0, 1'b0);
      k = cyc;
      while (cyc < k + 2 + 13 * CPB + 5) @(posedge clk);
      #2;
      check_val("prereset uart_tx", {31'd0, bus.uart_tx}, 32'd0);
      check_val("prereset busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b0;
      drive_state(4'd0, 4'd0, 1'b0, 1'b0);
      #1;
      check_val("midreset uart_tx", {31'd0, bus.uart_tx}, 32'd1);
      check_val("midreset busy", {31'd0, bus.busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      quiet("post reset", 2 * PKT_CYC);
      check_val("post reset packet count", pkt_cnt, c0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_telemetry_tx.md
Name: pong_telemetry_tx

Overview:
- UART transmitter: the host-bound counterpart of the UART receive path in the input bridge.
- Watches game state (scores, game_over, game_startup) and sends a 4-byte status packet, 8N1, whenever that state changes or a send is forced.
- Sits in the 50 MHz clk domain beside input_bridge and drives the board uart_tx pin.
- Game-state inputs arrive already synchronised to clk; CDC from clk_0 lives outside this block.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer truncation, 434 at defaults), clock cycles per serial bit.
- SYNC_BYTE, 8'hA5, packet header byte.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  asynchronous, active-low reset.
- score_p1  input  4  player 1 score, 0-15.
- score_p2  input  4  player 2 score, 0-15.
- game_over  input  1  game-over flag.
- game_startup  input  1  start-menu/startup flag.
- force_send  input  1  single-cycle pulse; requests a packet regardless of change.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  high from packet start until the stop bit of byte 3 completes.
- pkt_sent  output  1  one-cycle pulse at the end of each packet's final stop bit.

Behaviour:
- Reset (rst low, asynchronous):
  - uart_tx=1, busy=0, pkt_sent=0.
  - Baud counter, bit index and byte index all 0.
  - Last-sent snapshot = {0,0,0,0}; pending=0.
- Status vector S = {score_p1, score_p2, game_over, game_startup}, 10 bits, registered every cycle.
- Trigger: registered S differs from last-sent snapshot, OR force_send was high on the previous edge.
- Packet format, bytes sent in order, each LSB first:
  - B0 = SYNC_BYTE.
  - B1 = {score_p1, score_p2}.
  - B2 = {6'b0, game_startup, game_over}.
  - B3 = B0^B1^B2.
- Snapshot latching:
  - S is latched into the packet buffer and the last-sent snapshot on the edge that leaves IDLE.
  - Later input changes never alter a packet already in flight.
- Top FSM states:
  - IDLE: waits for trigger, or for pending=1. Then latches S, clears pending, sets busy, goes to SEND.
  - SEND: hands B0..B3 to the byte serialiser one at a time via a valid/ready handshake. The next byte is presented in the same cycle ready rises, so there is no idle gap between bytes. After B3's stop bit, goes to DONE.
  - DONE: one cycle. pkt_sent=1, busy=0, returns to IDLE.
- Latency: uart_tx falls (start bit of B0) on the second rising edge after the changed input is presented.
- Framing:
  - Each byte = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - One packet = 40 bit times (17,360 cycles at defaults).
- Trigger while busy: sets pending=1. Multiple triggers collapse into a single pending packet, which carries the values current when it starts.
- Simultaneous force_send and state change: exactly one packet.
- force_send with unchanged S: packet sent with the current values.
- Reset mid-packet: uart_tx returns high immediately and the partial frame is abandoned. No packet is sent after reset release unless S differs from zero or force_send is pulsed.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; width is $clog2(CLKS_PER_BIT).

Decomposition:
- Shared package (pong_pkg) holds:
  - SYNC_BYTE and the packet length constant (4).
  - Flag bit positions in B2 (GAME_OVER_BIT=0, STARTUP_BIT=1).
  - The CLKS_PER_BIT calculation, reused by the UART receive path.
- Sub-module uart_tx_byte:
  - Ports: clk, rst, data[7:0], valid, ready, tx.
  - Owns the baud counter and bit shifter.
  - ready is high in idle, and again in the cycle its stop bit completes.
- Top level holds the snapshot, change detection, pending flag and packet FSM.

Test Plan:
- Reset, then hold inputs at zero for 50,000 cycles -> uart_tx stays 1, busy=0, no pkt_sent.
- Set score_p1=3, score_p2=5 -> bytes decode as A5, 35, 00, 90. Start bit falls 2 edges after the change, each bit lasts 434 cycles, and pkt_sent pulses once after 17,360 cycles.
- score_p1=9, score_p2=7, game_over=1 -> packet A5, 97, 01, 33.
- During a packet, change score_p2 three times (final value 6, score_p1=3) -> the current packet is unchanged, and exactly one follow-up packet A5, 36, 00, 93 follows immediately after pkt_sent.
- force_send pulse with unchanged state (3/6) -> one packet A5, 36, 00, 93. force_send coincident with a score change -> exactly one packet.
- Assert rst mid-byte of B1 -> uart_tx=1 and busy=0 immediately. After release with inputs zero, nothing is sent.
